// File: rtl/rat_stack_unit.sv
// Downward-growing return-address stack with a registered pop port and push/pop exchange.
// Optional `RAT_STACK_BOUNDS_EN rejects overflowing pushes and underflowing pops and flags them.
module rat_stack_unit #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  ld_sp_i,
  input  logic [DEPTH_LOG2-1:0] sp_din_i,
  input  logic [DATA_W-1:0]     din_i,
  output logic [DATA_W-1:0]     dout_o,
  output logic                  dout_valid_o,
  output logic [DEPTH_LOG2-1:0] sp_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  ovf_err_o,
  output logic                  unf_err_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] SP_ONE   = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] sp_q, sp_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_W-1:0]     dout_q;
  logic                  valid_q;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  we, rd_en;
  logic [DEPTH_LOG2-1:0] waddr;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);

  // Next-state: LD_SP beats push/pop; push+pop on a non-empty stack swaps the top entry.
  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    rd_en   = 1'b0;
    waddr   = sp_q;
    if (ld_sp_i) begin
      sp_d    = sp_din_i;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (push_i && pop_i && !empty_o) begin
      we    = 1'b1;
      rd_en = 1'b1;
    end else if (push_i) begin
`ifdef RAT_STACK_BOUNDS_EN
      if (pop_i) unf_d = 1'b1;
      if (full_o) begin
        ovf_d = 1'b1;
      end else begin
        we      = 1'b1;
        waddr   = sp_q - SP_ONE;
        sp_d    = sp_q - SP_ONE;
        count_d = count_q + CNT_ONE;
      end
`else
      we    = 1'b1;
      waddr = sp_q - SP_ONE;
      sp_d  = sp_q - SP_ONE;
      if (!full_o) count_d = count_q + CNT_ONE;
`endif
    end else if (pop_i) begin
`ifdef RAT_STACK_BOUNDS_EN
      if (empty_o) begin
        unf_d = 1'b1;
      end else begin
        rd_en   = 1'b1;
        sp_d    = sp_q + SP_ONE;
        count_d = count_q - CNT_ONE;
      end
`else
      rd_en = 1'b1;
      sp_d  = sp_q + SP_ONE;
      if (!empty_o) count_d = count_q - CNT_ONE;
`endif
    end
  end

  // Control/status registers; the read data is captured on the pop edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sp_q    <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      valid_q <= rd_en;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (rd_en) dout_q <= mem_q[sp_q];
    end
  end

  // Storage is never cleared; reset only suppresses a pending write.
  always_ff @(posedge clk_i) begin
    if (we && !rst_i) mem_q[waddr] <= din_i;
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign sp_o         = sp_q;
  assign count_o      = count_q;
  assign ovf_err_o    = ovf_q;
  assign unf_err_o    = unf_q;

endmodule

// File: doc/rat_stack_unit.md
RAT_STACK_UNIT -- requirements
Module: rat_stack_unit

Interface
REQ-001 Parameter DATA_W, default 10, is the stack word width (holds a full PC or a zero-extended register).
REQ-002 Parameter DEPTH_LOG2, default 8, is the stack address width; depth DEPTH = 2**DEPTH_LOG2.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 CLK  in  1  system clock; all state updates on rising edge.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 PUSH  in  1  push DIN this cycle.
REQ-007 POP  in  1  pop top-of-stack this cycle.
REQ-008 LD_SP  in  1  load stack pointer from SP_DIN.
REQ-009 SP_DIN  in  DEPTH_LOG2  new stack pointer value.
REQ-010 DIN  in  DATA_W  push data.
REQ-011 DOUT  out  DATA_W  last popped word, held until next accepted pop.
REQ-012 DOUT_VALID  out  1  one-cycle pulse, high the cycle after an accepted pop.
REQ-013 SP  out  DEPTH_LOG2  current stack pointer.
REQ-014 COUNT  out  DEPTH_LOG2+1  number of entries pushed since reset or last LD_SP.
REQ-015 FULL / EMPTY  out  1 each  COUNT==DEPTH / COUNT==0, combinational from COUNT.
REQ-016 OVF_ERR / UNF_ERR  out  1 each  sticky overflow / underflow flags.

Function
REQ-017 Stack SHALL grow downward: accepted push writes DIN at address SP-1 (mod DEPTH), then SP <= SP-1, COUNT <= COUNT+1.
REQ-018 Accepted pop SHALL read address SP, then SP <= SP+1 (mod DEPTH), COUNT <= COUNT-1.
REQ-019 Pop latency SHALL be exactly 1 cycle: DOUT updates and DOUT_VALID pulses on the edge after the POP cycle.
REQ-020 Storage SHALL be a DEPTH x DATA_W synchronous-write, synchronous-read array.
REQ-021 Priority: RST > LD_SP > PUSH/POP.
REQ-022 LD_SP SHALL set SP <= SP_DIN and COUNT <= 0; PUSH/POP in the same cycle are ignored, and no DOUT_VALID is produced.
REQ-023 PUSH and POP together with COUNT>0 SHALL exchange the top: DOUT gets old mem[SP], mem[SP] <= DIN, SP and COUNT unchanged, DOUT_VALID pulses.
REQ-024 PUSH and POP together with COUNT==0 SHALL act as PUSH alone; the pop is dropped (UNF_ERR rules per REQ-029/031 apply).
REQ-025 Write-then-read hazard: a pop in the cycle after a push SHALL return the just-pushed word.
REQ-026 SP wrap-around: SP SHALL wrap 0 -> DEPTH-1 on push and DEPTH-1 -> 0 on pop.
REQ-027 With neither PUSH, POP, nor LD_SP asserted, all state SHALL hold; DOUT_VALID SHALL be 0.

Reset
REQ-028 On RST: SP=0, COUNT=0, DOUT=0, DOUT_VALID=0, OVF_ERR=0, UNF_ERR=0; array contents are not cleared; reset mid-push/pop aborts the operation with no array write.

Configuration
REQ-029 Macro RAT_STACK_BOUNDS_EN defined: push with FULL is rejected (no write, SP/COUNT hold) and sets OVF_ERR; pop with EMPTY is rejected (no DOUT update, no DOUT_VALID) and sets UNF_ERR; both flags are sticky, cleared only by RST or LD_SP.
REQ-030 Macro undefined, push with FULL: push proceeds, overwriting the oldest entry; SP moves; COUNT saturates at DEPTH.
REQ-031 Macro undefined, pop with EMPTY: pop proceeds, reading mem[SP] with DOUT_VALID pulsed; SP increments; COUNT stays 0; OVF_ERR and UNF_ERR are tied 0.

Verification
REQ-032 RST, push 0x155, 0x2AA, pop, pop -> SP 0x00->0xFF->0xFE->0xFF->0x00; DOUT 0x2AA then 0x155, each with a one-cycle DOUT_VALID; EMPTY=1 at end.
REQ-033 Push 0x011, then PUSH+POP with DIN=0x022 -> DOUT=0x011, SP=0xFF, COUNT=1; following pop -> DOUT=0x022.
REQ-034 LD_SP with SP_DIN=0x10 while PUSH=1 -> SP=0x10, COUNT=0, no write; next push 0x3FF writes address 0x0F.
REQ-035 256 pushes then one more: with macro -> FULL=1, OVF_ERR=1, SP=0x00 unchanged; without macro -> SP=0xFF, COUNT=256, mem[0xFF] overwritten.
REQ-036 Pop on empty after reset: with macro -> UNF_ERR=1, DOUT_VALID=0, SP=0x00; without macro -> DOUT_VALID=1, SP=0x01.
REQ-037 RST asserted in the same cycle as PUSH of 0x3C3 with SP=0x40 -> SP=0, COUNT=0, all outputs at reset values, and mem[0x3F] unchanged.
